// File: rtl/data_cache_pkg.sv
// Shared types and default geometry for the direct-mapped write-through data cache.
package data_cache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  localparam logic MEMTYPE_BYTE = 1'b1;
  localparam logic MEMTYPE_WORD = 1'b0;

  localparam int DC_WIDTH          = 32;
  localparam int DC_SETS           = 16;
  localparam int DC_WORDS_PER_LINE = 4;

  // Byte-address field widths for the default geometry: {tag, idx, word, off}
  localparam int DC_OFF_W  = 2;
  localparam int DC_WORD_W = $clog2(DC_WORDS_PER_LINE);
  localparam int DC_IDX_W  = $clog2(DC_SETS);
  localparam int DC_TAG_W  = DC_WIDTH - DC_OFF_W - DC_WORD_W - DC_IDX_W;

endpackage

// File: rtl/data_cache_array.sv
// Valid/tag/data storage: combinational read of one word, byte-enabled word write, line fill/invalidate.
// Valid bits reset asynchronously; tag and data storage are never reset.
module data_cache_array
  import data_cache_pkg::*;
#(
  parameter int WIDTH          = DC_WIDTH,
  parameter int SETS           = DC_SETS,
  parameter int WORDS_PER_LINE = DC_WORDS_PER_LINE,
  parameter int IDX_W          = $clog2(SETS),
  parameter int WORD_W         = $clog2(WORDS_PER_LINE),
  parameter int TAG_W          = WIDTH - 2 - WORD_W - IDX_W,
  parameter int NB             = WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [WORD_W-1:0] i_word,
  output logic              o_valid,
  output logic [TAG_W-1:0]  o_tag,
  output logic [WIDTH-1:0]  o_word,
  input  logic              i_wr_en,
  input  logic [NB-1:0]     i_wr_be,
  input  logic [WIDTH-1:0]  i_wr_dat,
  input  logic              i_inv,
  input  logic              i_fill,
  input  logic [TAG_W-1:0]  i_fill_tag
);

  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [WIDTH-1:0] r_data [SETS*WORDS_PER_LINE];

  logic [IDX_W+WORD_W-1:0] w_waddr;

  assign w_waddr = {i_idx, i_word};
  assign o_valid = r_valid[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_word  = r_data[w_waddr];

  // A fill completes a line; an invalidate marks the start of an overwrite.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_fill) begin
      r_valid[i_idx] <= 1'b1;
    end else if (i_inv) begin
      r_valid[i_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_fill) begin
      r_tag[i_idx] <= i_fill_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wr_be[b]) begin
          r_data[w_waddr][8*b +: 8] <= i_wr_dat[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through no-write-allocate D-cache: hits/stores same cycle, misses stall 1+WORDS_PER_LINE cycles.
// Define DATA_CACHE_STATS_EN to add hit_count/miss_count outputs.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int WIDTH          = DC_WIDTH,
  parameter int SETS           = DC_SETS,
  parameter int WORDS_PER_LINE = DC_WORDS_PER_LINE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_re,
  input  logic             cpu_we,
  input  logic             cpu_memtype,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wd,
  output logic [WIDTH-1:0] cpu_rd,
  output logic             stall,
  output logic             mem_we,
  output logic             mem_memtype,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
`endif
);

  localparam int WORD_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = WIDTH - 2 - WORD_W - IDX_W;
  localparam int NB     = WIDTH / 8;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);

  state_t            r_state, w_state_nxt;
  logic [WORD_W-1:0] r_count;
  logic [TAG_W-1:0]  r_tag;
  logic [IDX_W-1:0]  r_idx;
  logic [WIDTH-1:0]  r_rd;

  logic [1:0]        w_off;
  logic [WORD_W-1:0] w_cword;
  logic [IDX_W-1:0]  w_cidx;
  logic [TAG_W-1:0]  w_ctag;

  logic [IDX_W-1:0]  w_arr_idx;
  logic [WORD_W-1:0] w_arr_word;
  logic              w_valid;
  logic [TAG_W-1:0]  w_tag;
  logic [WIDTH-1:0]  w_line_word;
  logic              w_wr_en;
  logic [NB-1:0]     w_wr_be;
  logic [WIDTH-1:0]  w_wr_dat;
  logic              w_fill;

  logic              w_refill, w_idle, w_hit, w_rd_req, w_rhit, w_rmiss, w_whit;
  logic [7:0]        w_byte;
  logic [WIDTH-1:0]  w_load;

  assign w_off   = cpu_addr[1:0];
  assign w_cword = cpu_addr[2 +: WORD_W];
  assign w_cidx  = cpu_addr[2+WORD_W +: IDX_W];
  assign w_ctag  = cpu_addr[WIDTH-1 -: TAG_W];

  // rst_n gates the request path so stall/mem_we drop immediately on reset assertion.
  assign w_refill = (r_state == REFILL);
  assign w_idle   = rst_n && (r_state == IDLE);

  assign w_arr_idx  = w_refill ? r_idx   : w_cidx;
  assign w_arr_word = w_refill ? r_count : w_cword;

  assign w_hit    = w_valid && (w_tag == w_ctag);
  assign w_rd_req = w_idle && cpu_re && !cpu_we;
  assign w_rhit   = w_rd_req && w_hit;
  assign w_rmiss  = w_rd_req && !w_hit;
  assign w_whit   = w_idle && cpu_we && w_hit;
  assign w_fill   = w_refill && (r_count == LAST_WORD);

  assign w_byte = w_line_word[8*w_off +: 8];
  assign w_load = (cpu_memtype == MEMTYPE_BYTE) ? {{(WIDTH-8){1'b0}}, w_byte} : w_line_word;
  assign cpu_rd = w_rhit ? w_load : r_rd;

  always_comb begin
    w_wr_en  = 1'b0;
    w_wr_be  = '0;
    w_wr_dat = mem_rd;
    if (w_refill) begin
      w_wr_en = 1'b1;
      w_wr_be = '1;
    end else if (w_whit) begin
      w_wr_en = 1'b1;
      if (cpu_memtype == MEMTYPE_BYTE) begin
        w_wr_be  = NB'(1) << w_off;
        w_wr_dat = {NB{cpu_wd[7:0]}};
      end else begin
        w_wr_be  = '1;
        w_wr_dat = cpu_wd;
      end
    end
  end

  data_cache_array #(
    .WIDTH          (WIDTH),
    .SETS           (SETS),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .IDX_W          (IDX_W),
    .WORD_W         (WORD_W),
    .TAG_W          (TAG_W),
    .NB             (NB)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_idx      (w_arr_idx),
    .i_word     (w_arr_word),
    .o_valid    (w_valid),
    .o_tag      (w_tag),
    .o_word     (w_line_word),
    .i_wr_en    (w_wr_en),
    .i_wr_be    (w_wr_be),
    .i_wr_dat   (w_wr_dat),
    .i_inv      (w_rmiss),
    .i_fill     (w_fill),
    .i_fill_tag (r_tag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_tag   <= '0;
      r_idx   <= '0;
      r_rd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rmiss) begin
        r_count <= '0;
        r_tag   <= w_ctag;
        r_idx   <= w_cidx;
      end else if (w_refill) begin
        r_count <= r_count + 1'b1;
      end
      if (w_rhit) begin
        r_rd <= w_load;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    mem_we      = 1'b0;
    mem_memtype = cpu_memtype;
    mem_addr    = cpu_addr;
    mem_wd      = cpu_wd;
    case (r_state)
      IDLE: begin
        stall  = w_rmiss;
        mem_we = w_idle && cpu_we;
        if (w_rmiss) begin
          w_state_nxt = REFILL;
        end
      end
      REFILL: begin
        stall       = 1'b1;
        mem_memtype = MEMTYPE_WORD;
        mem_addr    = {r_tag, r_idx, r_count, 2'b00};
        if (r_count == LAST_WORD) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef DATA_CACHE_STATS_EN
  logic [31:0] r_hit_count, r_miss_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_rhit) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_rmiss) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Randomized scoreboard bench for data_cache against a line-residency model and a reference byte memory.
module tb_data_cache;

  localparam int WPL  = 4;
  localparam int SETS = 16;
  localparam int K_LOAD = 0, K_STORE = 1, K_IDLE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_re = 1'b0, cpu_we = 1'b0, cpu_memtype = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wd = '0;
  logic [31:0] cpu_rd;
  logic        stall, mem_we, mem_memtype;
  logic [31:0] mem_addr, mem_wd;
  logic [31:0] mem_rd;
`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  data_cache dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_re      (cpu_re),
    .cpu_we      (cpu_we),
    .cpu_memtype (cpu_memtype),
    .cpu_addr    (cpu_addr),
    .cpu_wd      (cpu_wd),
    .cpu_rd      (cpu_rd),
    .stall       (stall),
    .mem_we      (mem_we),
    .mem_memtype (mem_memtype),
    .mem_addr    (mem_addr),
    .mem_wd      (mem_wd),
    .mem_rd      (mem_rd)
`ifdef DATA_CACHE_STATS_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  // Device memory (driven by the DUT) and reference memory (driven by the stimulus) share initial contents.
  logic [7:0] dev_mem [int unsigned];
  logic [7:0] ref_mem [int unsigned];
  int mem_gen = 0;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ {a[22:16], 1'b0} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] get_byte(input bit use_ref, input logic [31:0] a);
    if (use_ref) return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    return dev_mem.exists(a) ? dev_mem[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] get_word(input bit use_ref, input logic [31:0] a);
    logic [31:0] base;
    base = {a[31:2], 2'b00};
    return {get_byte(use_ref, base + 3), get_byte(use_ref, base + 2),
            get_byte(use_ref, base + 1), get_byte(use_ref, base)};
  endfunction

  always @(mem_addr or mem_gen) mem_rd = get_word(1'b0, mem_addr);

  always @(posedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      if (mem_memtype) begin
        dev_mem[mem_addr] = mem_wd[7:0];
      end else begin
        for (int b = 0; b < 4; b++) dev_mem[{mem_addr[31:2], 2'b00} + b] = mem_wd[8*b +: 8];
      end
      mem_gen++;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          stalls;
    logic [31:0] addr;
    logic        memtype;
  } exp_t;

  exp_t q[$];
  logic op_vld = 1'b0;

  // Model: which tag is resident per set; resident lines always mirror memory under write-through.
  bit          ref_valid [SETS];
  logic [23:0] ref_tag   [SETS];
  logic [31:0] ref_last = '0;
  int          n_hit = 0, n_miss = 0;

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) ref_valid[s] = 1'b0;
    ref_last = '0;
    n_hit = 0;
    n_miss = 0;
  endtask

  task automatic do_op(input int kind, input logic mt, input logic [31:0] addr,
                       input logic [31:0] wd, input bit both);
    exp_t e;
    int idx, n;
    logic [23:0] tg;
    idx = int'((addr >> 4) % SETS);
    tg  = addr[31:8];
    e.kind = kind; e.addr = addr; e.memtype = mt; e.stalls = 0; e.data = '0;
    if (kind == K_LOAD) begin
      if (!(ref_valid[idx] && ref_tag[idx] == tg)) begin
        n_miss++;
        e.stalls = 1 + WPL;
        ref_valid[idx] = 1'b1;
        ref_tag[idx] = tg;
      end
      n_hit++;  // a load always ends on a hit, after a refill if it missed
      e.data = mt ? {24'b0, get_byte(1'b1, addr)} : get_word(1'b1, addr);
      ref_last = e.data;
    end else if (kind == K_STORE) begin
      e.data = wd;
      if (mt) ref_mem[addr] = wd[7:0];
      else for (int b = 0; b < 4; b++) ref_mem[{addr[31:2], 2'b00} + b] = wd[8*b +: 8];
    end else begin
      e.data = ref_last;
    end
    q.push_back(e);
    cpu_re = (kind == K_LOAD) || both;
    cpu_we = (kind == K_STORE);
    cpu_memtype = mt;
    cpu_addr = addr;
    cpu_wd = wd;
    op_vld = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall && n < 20);
    if (stall) chk("stall_timeout", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    cpu_re = 1'b0;
    cpu_we = 1'b0;
    op_vld = 1'b0;
  endtask

  int stall_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || !op_vld) begin
      stall_cnt = 0;
    end else if (stall) begin
      stall_cnt++;
      if (stall_cnt >= 2 && q.size() > 0) begin
        chk("refill_addr", mem_addr, (q[0].addr & ~32'hF) + 32'(4 * (stall_cnt - 2)));
        chk("refill_we", 32'(mem_we), 32'd0);
      end
    end else begin
      if (q.size() == 0) begin
        chk("unexpected_response", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        case (e.kind)
          K_LOAD: begin
            chk("load_data", cpu_rd, e.data);
            chk("load_stalls", 32'(stall_cnt), 32'(e.stalls));
          end
          K_STORE: begin
            chk("store_we", 32'(mem_we), 32'd1);
            chk("store_addr", mem_addr, e.addr);
            chk("store_wd", mem_wd, e.data);
            chk("store_type", 32'(mem_memtype), 32'(e.memtype));
          end
          default: begin
            chk("idle_we", 32'(mem_we), 32'd0);
            chk("idle_hold", cpu_rd, e.data);
          end
        endcase
      end
      stall_cnt = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bases [4];
    logic [31:0] addr;
    int r;
    bases[0] = 32'h10000; bases[1] = 32'h10400; bases[2] = 32'h20000; bases[3] = 32'h7F300;
    model_reset();

    #12;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_cpu_rd", cpu_rd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op(K_LOAD,  1'b0, 32'h10000, '0, 1'b0);
    do_op(K_LOAD,  1'b0, 32'h10004, '0, 1'b0);
    do_op(K_STORE, 1'b0, 32'h10008, 32'h12345678, 1'b0);
    do_op(K_LOAD,  1'b1, 32'h1000B, '0, 1'b0);
    do_op(K_IDLE,  1'b0, 32'h0, '0, 1'b0);
    do_op(K_STORE, 1'b1, 32'h20000, 32'h000000AB, 1'b0);
    do_op(K_LOAD,  1'b1, 32'h20000, '0, 1'b0);
    do_op(K_LOAD,  1'b0, 32'h10000, '0, 1'b0);
    do_op(K_LOAD,  1'b0, 32'h10400, '0, 1'b0);
    do_op(K_LOAD,  1'b0, 32'h10000, '0, 1'b0);
    do_op(K_STORE, 1'b0, 32'h10010, 32'hCAFEF00D, 1'b1);
    do_op(K_LOAD,  1'b0, 32'h10010, '0, 1'b0);

    // Reset asserted in the second refill cycle aborts the fill.
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_memtype = 1'b0; cpu_addr = 32'h30000;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("refill_active", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_cpu_rd", cpu_rd, 32'd0);
    model_reset();
    cpu_re = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(K_LOAD, 1'b0, 32'h30000, '0, 1'b0);
    do_op(K_LOAD, 1'b0, 32'h10010, '0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      addr = bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 255));
      if (r < 40)      do_op(K_LOAD,  1'b0, addr, '0, 1'b0);
      else if (r < 60) do_op(K_LOAD,  1'b1, addr, '0, 1'b0);
      else if (r < 75) do_op(K_STORE, 1'b0, addr, $urandom, 1'b0);
      else if (r < 88) do_op(K_STORE, 1'b1, addr, $urandom, 1'b0);
      else if (r < 94) do_op(K_STORE, 32'($urandom) % 2 == 1, addr, $urandom, 1'b1);
      else             do_op(K_IDLE,  1'b0, addr, '0, 1'b0);
    end

    chk("queue_drained", 32'(q.size()), 32'd0);
`ifdef DATA_CACHE_STATS_EN
    chk("hit_count", hit_count, 32'(n_hit));
    chk("miss_count", miss_count, 32'(n_miss));
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
